// File: rtl/beam_rank_collect.sv
// beam_rank_collect: ping-pong rank table that scatters scored beats and
// streams the TOPK best-ranked entries of each completed frame.
module beam_rank_collect #(
    parameter int IW   = 32,
    parameter int COL  = 16,
    parameter int TOPK = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [7:0]    i_score,
    input  logic [7:0]    i_index,
    input  logic [IW-1:0] i_data,
    input  logic          i_tvalid,
    output logic [7:0]    o_index,
    output logic [IW-1:0] o_data,
    output logic [7:0]    o_rank,
    output logic          o_tvalid,
    output logic          o_tlast,
    input  logic          i_tready,
    output logic          o_frm_err,
    output logic          o_ovf_err
);

    localparam int AW = $clog2(COL);
    localparam int SW = 8 + IW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_t;

    logic [SW-1:0]  mem_q [2][COL];
    logic [COL-1:0] bm_q [2];
    logic [1:0]     dup_q;
    logic [AW-1:0]  wr_cnt_q;
    logic           wr_bank_q;
    logic           rd_bank_q;
    state_t         state_q;

    logic [7:0]     o_index_q;
    logic [IW-1:0]  o_data_q;
    logic [7:0]     o_rank_q;
    logic           o_tvalid_q;
    logic           o_frm_err_q;

    logic           wr_ok;
    logic [AW-1:0]  wr_addr;
    logic           wr_hit;
    logic [COL-1:0] bm_new;
    logic           dup_new;
    logic           last_beat;
    logic           rd_idle;
    logic           handover;

    assign wr_ok     = i_tvalid && (i_score < 8'(COL));
    assign wr_addr   = i_score[AW-1:0];
    assign wr_hit    = bm_q[wr_bank_q][wr_addr];
    assign bm_new    = bm_q[wr_bank_q] | (wr_ok ? (COL'(1) << wr_addr) : '0);
    assign dup_new   = dup_q[wr_bank_q] | (i_tvalid && (!wr_ok || wr_hit));
    assign last_beat = i_tvalid && (wr_cnt_q == AW'(COL - 1));
    assign rd_idle   = (state_q == S_IDLE);
    assign handover  = last_beat && rd_idle;

    // Slot contents carry no reset; the bitmap alone says what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem_q[wr_bank_q][wr_addr] <= {i_index, i_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            bm_q[0]   <= '0;
            bm_q[1]   <= '0;
            dup_q     <= '0;
        end else if (i_tvalid) begin
            if (last_beat) begin
                wr_cnt_q <= '0;
                if (rd_idle) begin
                    bm_q[wr_bank_q]   <= bm_new;
                    dup_q[wr_bank_q]  <= dup_new;
                    bm_q[~wr_bank_q]  <= '0;
                    dup_q[~wr_bank_q] <= 1'b0;
                    wr_bank_q         <= ~wr_bank_q;
                end else begin
                    bm_q[wr_bank_q]  <= '0;
                    dup_q[wr_bank_q] <= 1'b0;
                end
            end else begin
                wr_cnt_q         <= wr_cnt_q + 1'b1;
                bm_q[wr_bank_q]  <= bm_new;
                dup_q[wr_bank_q] <= dup_new;
            end
        end
    end

    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_word;
    logic          rd_hit;
    logic [7:0]    rd_index;
    logic [IW-1:0] rd_data;

    assign rd_addr  = (state_q == S_LOAD) ? '0 : AW'(o_rank_q + 8'd1);
    assign rd_word  = mem_q[rd_bank_q][rd_addr];
    assign rd_hit   = bm_q[rd_bank_q][rd_addr];
    assign rd_index = rd_hit ? rd_word[SW-1 -: 8] : 8'hFF;
    assign rd_data  = rd_hit ? rd_word[IW-1:0] : '0;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            rd_bank_q   <= 1'b0;
            o_index_q   <= '0;
            o_data_q    <= '0;
            o_rank_q    <= '0;
            o_tvalid_q  <= 1'b0;
            o_frm_err_q <= 1'b0;
        end else begin
            o_frm_err_q <= handover && (!(&bm_new) || dup_new);
            unique case (state_q)
                S_IDLE: begin
                    if (handover) begin
                        rd_bank_q <= wr_bank_q;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    o_index_q  <= rd_index;
                    o_data_q   <= rd_data;
                    o_rank_q   <= '0;
                    o_tvalid_q <= 1'b1;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (o_tvalid_q && i_tready) begin
                        if (o_rank_q == 8'(TOPK - 1)) begin
                            o_tvalid_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            o_index_q <= rd_index;
                            o_data_q  <= rd_data;
                            o_rank_q  <= o_rank_q + 8'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_index   = o_index_q;
    assign o_data    = o_data_q;
    assign o_rank    = o_rank_q;
    assign o_tvalid  = o_tvalid_q;
    assign o_tlast   = o_tvalid_q && (o_rank_q == 8'(TOPK - 1));
    assign o_frm_err = o_frm_err_q;
    assign o_ovf_err = last_beat && !rd_idle;

endmodule

// File: tb/tb_beam_rank_collect.sv
// Scoreboard bench for beam_rank_collect: 16/8 and 64/64 instances
// checked against a rank-table reference model.
module tb_beam_rank_collect;

    localparam int IW   = 32;
    localparam int COL  = 16;
    localparam int TOPK = 8;
    localparam int C6   = 64;

    typedef struct {
        int          rank;
        int          idx;
        logic [31:0] data;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [7:0]    score, index;
    logic [IW-1:0] data;
    logic          tvalid, tready;
    logic [7:0]    o_index, o_rank;
    logic [IW-1:0] o_data;
    logic          o_tvalid, o_tlast, o_frm_err, o_ovf_err;

    logic [7:0]    score6, index6;
    logic [IW-1:0] data6;
    logic          tvalid6, tready6;
    logic [7:0]    o_index6, o_rank6;
    logic [IW-1:0] o_data6;
    logic          o_tvalid6, o_tlast6, o_frm_err6, o_ovf_err6;

    beam_rank_collect #(.IW(IW), .COL(COL), .TOPK(TOPK)) u_dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_score(score), .i_index(index), .i_data(data), .i_tvalid(tvalid),
        .o_index(o_index), .o_data(o_data), .o_rank(o_rank),
        .o_tvalid(o_tvalid), .o_tlast(o_tlast), .i_tready(tready),
        .o_frm_err(o_frm_err), .o_ovf_err(o_ovf_err)
    );

    beam_rank_collect #(.IW(IW), .COL(C6), .TOPK(C6)) u_dut64 (
        .i_clk(clk), .i_reset(rst_n),
        .i_score(score6), .i_index(index6), .i_data(data6), .i_tvalid(tvalid6),
        .o_index(o_index6), .o_data(o_data6), .o_rank(o_rank6),
        .o_tvalid(o_tvalid6), .o_tlast(o_tlast6), .i_tready(tready6),
        .o_frm_err(o_frm_err6), .o_ovf_err(o_ovf_err6)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    exp_t exp6[$];
    int   start_q[$], frm_q[$], ovf_q[$], st6[$];

    int          f_sc[COL];
    logic [31:0] f_dt[COL];
    int          tr_mode = 0;
    int          tr_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // downstream ready generator
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0: tready = 1'b1;
                1: begin tready = (tr_cnt % 3 == 0); tr_cnt++; end
                2: tready = ($urandom_range(0, 3) != 0);
                default: tready = 1'b0;
            endcase
        end
    end

    // monitor for the 16/8 instance
    bit          pv, pr;
    logic [7:0]  p_idx, p_rank;
    logic [31:0] p_data;
    initial begin
        pv = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 0;
            end else begin
                begin
                    bit ef, eo;
                    exp_t e;
                    ef = (frm_q.size() > 0) && (frm_q[0] == cyc);
                    eo = (ovf_q.size() > 0) && (ovf_q[0] == cyc);
                    if (ef) void'(frm_q.pop_front());
                    if (eo) void'(ovf_q.pop_front());
                    chk("frm_err", {63'd0, o_frm_err}, {63'd0, ef});
                    chk("ovf_err", {63'd0, o_ovf_err}, {63'd0, eo});
                    if (o_tvalid && !pv) begin
                        if (start_q.size() == 0) fail_now("start unexpected");
                        else chk("start_cyc", 64'(cyc), 64'(start_q.pop_front()));
                    end
                    if (pv && !pr)
                        chk("hold", {o_tvalid, o_rank, o_index, o_data},
                            {1'b1, p_rank, p_idx, p_data});
                    if (o_tvalid && tready) begin
                        if (exp_q.size() == 0) begin
                            fail_now("beat unexpected");
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat", {o_rank, o_index, o_data, o_tlast},
                                {8'(e.rank), 8'(e.idx), e.data, e.last});
                        end
                    end
                end
                pv = o_tvalid;
                pr = tready;
                p_idx = o_index;
                p_rank = o_rank;
                p_data = o_data;
            end
        end
    end

    // monitor for the 64/64 instance
    bit pv6;
    initial begin
        pv6 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv6 = 0;
            end else begin
                exp_t e;
                chk("err64", {62'd0, o_frm_err6, o_ovf_err6}, 64'd0);
                if (o_tvalid6 && !pv6) begin
                    if (st6.size() == 0) fail_now("start64 unexpected");
                    else chk("start64", 64'(cyc), 64'(st6.pop_front()));
                end
                if (o_tvalid6 && tready6) begin
                    if (exp6.size() == 0) begin
                        fail_now("beat64 unexpected");
                    end else begin
                        e = exp6.pop_front();
                        chk("beat64", {o_rank6, o_index6, o_data6, o_tlast6},
                            {8'(e.rank), 8'(e.idx), e.data, e.last});
                    end
                end
                pv6 = o_tvalid6;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            tvalid = 1'b0;
        end
    endtask

    // drive one frame of f_sc/f_dt and queue the model's response
    task automatic send_frame(input bit drop, input bit gaps);
        int slot[COL];
        int cnt[COL];
        bit err;
        int t;
        exp_t e;
        for (int i = 0; i < COL; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                    tvalid = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            tvalid = 1'b1;
            score = 8'(f_sc[i]);
            index = 8'(i);
            data = f_dt[i];
        end
        t = cyc;
        if (drop) begin
            ovf_q.push_back(t);
            return;
        end
        err = 0;
        for (int s = 0; s < COL; s++) begin
            slot[s] = -1;
            cnt[s] = 0;
        end
        for (int i = 0; i < COL; i++) begin
            if (f_sc[i] < COL) begin
                slot[f_sc[i]] = i;
                cnt[f_sc[i]]++;
            end else begin
                err = 1;
            end
        end
        for (int s = 0; s < COL; s++) if (cnt[s] != 1) err = 1;
        if (err) frm_q.push_back(t + 1);
        start_q.push_back(t + 2);
        for (int r = 0; r < TOPK; r++) begin
            e.rank = r;
            e.last = (r == TOPK - 1);
            if (slot[r] < 0) begin
                e.idx = 255;
                e.data = '0;
            end else begin
                e.idx = slot[r];
                e.data = f_dt[slot[r]];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic flush();
        exp_q.delete();
        start_q.delete();
        frm_q.delete();
        ovf_q.delete();
    endtask

    task automatic drain();
        int b = 0;
        while ((exp_q.size() || start_q.size() || frm_q.size() || ovf_q.size())
               && b < 2000) begin
            @(negedge clk);
            b++;
        end
        if (b >= 2000) begin
            fail_now("drain timeout");
            flush();
        end
        idle(3);
    endtask

    task automatic set_rev(input int base);
        for (int i = 0; i < COL; i++) begin
            f_sc[i] = COL - 1 - i;
            f_dt[i] = 32'(base + i);
        end
    endtask

    task automatic set_rand();
        bit perm;
        perm = $urandom_range(0, 1) == 1;
        for (int i = 0; i < COL; i++) begin
            f_sc[i] = perm ? i : int'($urandom_range(0, COL + 3));
            f_dt[i] = $urandom;
        end
        if (perm) begin
            for (int i = COL - 1; i > 0; i--) begin
                int j, tmp;
                j = int'($urandom_range(0, i));
                tmp = f_sc[i];
                f_sc[i] = f_sc[j];
                f_sc[j] = tmp;
            end
        end
    endtask

    task automatic send64();
        int perm[C6];
        logic [31:0] dt[C6];
        int inv[C6];
        exp_t e;
        for (int i = 0; i < C6; i++) begin
            perm[i] = i;
            dt[i] = $urandom;
        end
        for (int i = C6 - 1; i > 0; i--) begin
            int j, tmp;
            j = int'($urandom_range(0, i));
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int i = 0; i < C6; i++) inv[perm[i]] = i;
        for (int i = 0; i < C6; i++) begin
            @(posedge clk);
            #1;
            tvalid6 = 1'b1;
            score6 = 8'(perm[i]);
            index6 = 8'(i);
            data6 = dt[i];
        end
        st6.push_back(cyc + 2);
        for (int r = 0; r < C6; r++) begin
            e.rank = r;
            e.idx = inv[r];
            e.data = dt[inv[r]];
            e.last = (r == C6 - 1);
            exp6.push_back(e);
        end
        @(posedge clk);
        #1;
        tvalid6 = 1'b0;
        for (int b = 0; b < 500 && (exp6.size() || st6.size()); b++) @(negedge clk);
        if (exp6.size() || st6.size()) begin
            fail_now("drain64 timeout");
            exp6.delete();
            st6.delete();
        end
        idle(3);
    endtask

    initial begin
        rst_n = 1'b0;
        tvalid = 1'b0; score = '0; index = '0; data = '0;
        tvalid6 = 1'b0; score6 = '0; index6 = '0; data6 = '0;
        tready6 = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out", {o_index, o_data, o_rank, o_tvalid, o_tlast, o_frm_err, o_ovf_err}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        set_rev(100);
        send_frame(0, 0);
        idle(1);
        drain();

        tr_mode = 1;
        tr_cnt = 0;
        send_frame(0, 0);
        idle(1);
        drain();
        tr_mode = 0;

        for (int i = 0; i < COL; i++) begin
            f_sc[i] = i;
            f_dt[i] = 32'(500 + i);
        end
        f_sc[2] = 3;
        f_sc[3] = 2;
        f_sc[5] = 2;
        f_sc[7] = 5;
        send_frame(0, 0);
        idle(1);
        drain();

        tr_mode = 3;
        set_rev(200);
        send_frame(0, 0);
        set_rand();
        send_frame(1, 0);
        idle(20);
        tr_mode = 0;
        drain();

        set_rev(300);
        send_frame(0, 0);
        idle(1);
        begin
            int b = 0;
            while (!(o_tvalid && o_rank == 8'd3) && b < 50) begin
                @(negedge clk);
                b++;
            end
            if (b >= 50) fail_now("rank3 timeout");
        end
        #1;
        rst_n = 1'b0;
        flush();
        #1;
        chk("midreset_out", {o_index, o_data, o_rank, o_tvalid, o_tlast, o_frm_err, o_ovf_err}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_rev(400);
        send_frame(0, 0);
        idle(1);
        drain();

        for (int k = 0; k < 12; k++) begin
            tr_mode = int'($urandom_range(0, 2));
            set_rand();
            send_frame(0, 1);
            idle(1);
            drain();
        end
        tr_mode = 0;

        for (int k = 0; k < 3; k++) begin
            set_rand();
            send_frame(0, 0);
        end
        idle(1);
        drain();

        send64();
        send64();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
